// File: rtl/obstacle_sensor_frontend.sv
// obstacle_sensor_frontend
// Conditions time-multiplexed front/left/right range samples for the
// collision-avoidance controller: 4-tap moving average per channel,
// hysteresis obstacle detection, front slow band and qualified lane-clear.
// Optional stale-sensor watchdog enabled by defining STALE_WATCHDOG_EN.
module obstacle_sensor_frontend #(
  parameter int DIST_W     = 8,
  parameter int NEAR_TH    = 20,
  parameter int HYST       = 4,
  parameter int SLOW_TH    = 50,
  parameter int CLEAR_TH   = 80,
  parameter int CLEAR_HOLD = 3,
  parameter int TIMEOUT    = 1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sample_valid,
  output logic              sample_ready,
  input  logic [1:0]        sample_channel,
  input  logic [DIST_W-1:0] sample_distance,
  output logic              front_obstacle_detected,
  output logic              left_obstacle_detected,
  output logic              right_obstacle_detected,
  output logic              front_obstacle_slow,
  output logic              lane_clear_left,
  output logic              lane_clear_right,
  output logic [DIST_W-1:0] front_dist_filt,
  output logic [2:0]        sensor_stale,
  output logic              err_bad_channel
);

  localparam int SUM_W = DIST_W + 2;
  localparam int CMP_W = DIST_W + 2;
  localparam int CNT_W = (CLEAR_HOLD < 2) ? 1 : $clog2(CLEAR_HOLD + 1);

  localparam logic [SUM_W-1:0] SUM_INIT  = {{DIST_W{1'b1}}, 2'b00};
  localparam logic [CMP_W-1:0] NEAR_V    = CMP_W'(NEAR_TH);
  localparam logic [CMP_W-1:0] RELEASE_V = CMP_W'(NEAR_TH + HYST);
  localparam logic [CMP_W-1:0] SLOW_V    = CMP_W'(SLOW_TH);
  localparam logic [CMP_W-1:0] CLEAR_V   = CMP_W'(CLEAR_TH);
  localparam logic [CNT_W-1:0] HOLD_V    = CNT_W'(CLEAR_HOLD);

  localparam logic [0:0] ST_ACCEPT = 1'b0;
  localparam logic [0:0] ST_UPDATE = 1'b1;

  // Filtered value: running sum divided by four, truncated.
  function automatic logic [DIST_W-1:0] filt_of(input logic [SUM_W-1:0] s);
    return s[SUM_W-1:2];
  endfunction

  // Running-sum update; the sum of four DIST_W samples always fits SUM_W.
  function automatic logic [SUM_W-1:0] sum_next(input logic [SUM_W-1:0] s,
                                                input logic [DIST_W-1:0] add,
                                                input logic [DIST_W-1:0] drop);
    return s + {2'b00, add} - {2'b00, drop};
  endfunction

  // Hysteresis: set below NEAR_TH, clear at NEAR_TH+HYST or above, else hold.
  function automatic logic hyst_next(input logic prev, input logic [DIST_W-1:0] f);
    if ({2'b00, f} < NEAR_V)
      return 1'b1;
    else if ({2'b00, f} >= RELEASE_V)
      return 1'b0;
    else
      return prev;
  endfunction

  function automatic logic in_slow_band(input logic [DIST_W-1:0] f);
    return ({2'b00, f} >= NEAR_V) && ({2'b00, f} < SLOW_V);
  endfunction

  // Saturating increment of the lane-clear qualification counter.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c >= HOLD_V) ? HOLD_V : c + 1'b1;
  endfunction

  function automatic logic [CNT_W-1:0] clear_cnt_next(input logic [CNT_W-1:0] c,
                                                      input logic [DIST_W-1:0] f);
    return ({2'b00, f} >= CLEAR_V) ? sat_inc(c) : '0;
  endfunction

  logic [0:0]        state;
  logic              xfer;
  logic              vld_p0;
  logic [1:0]        ch_p0;
  logic [DIST_W-1:0] dist_p0;
  logic              vld_p1;
  logic [1:0]        ch_p1;

  logic [DIST_W-1:0] hist [3][4];
  logic [SUM_W-1:0]  sum  [3];
  logic [DIST_W-1:0] filt [3];
  logic [2:0]        upd;
  logic [2:0]        obst;
  logic [2:0]        obst_n;
  logic              slow;
  logic [CNT_W-1:0]  clr_cnt   [2];
  logic [CNT_W-1:0]  clr_cnt_n [2];
  logic [1:0]        lane;
  logic [2:0]        force_fs;
  logic [2:0]        stale_vec;

  assign sample_ready = (state == ST_ACCEPT);
  assign xfer         = sample_valid && sample_ready;

  // Handshake FSM: one accept cycle, then one update cycle with ready low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= ST_ACCEPT;
    else if (state == ST_UPDATE)
      state <= ST_ACCEPT;
    else if (xfer)
      state <= ST_UPDATE;
  end

  // ---- p0: capture accepted sample ----
  // Valid marker for the captured sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      vld_p0 <= 1'b0;
    else
      vld_p0 <= xfer;
  end

  // Sample payload; only meaningful while vld_p0 is high.
  always_ff @(posedge clk) begin
    if (xfer) begin
      ch_p0   <= sample_channel;
      dist_p0 <= sample_distance;
    end
  end

  // ---- p1: history and running sum ----
  // Shift the new sample into its channel history and update the sum.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < 3; c++) begin
        sum[c] <= SUM_INIT;
        for (int t = 0; t < 4; t++)
          hist[c][t] <= '1;
      end
    end else if (vld_p0) begin
      for (int c = 0; c < 3; c++) begin
        if (ch_p0 == 2'(c)) begin
          sum[c]     <= sum_next(sum[c], dist_p0, hist[c][3]);
          hist[c][0] <= dist_p0;
          for (int t = 1; t < 4; t++)
            hist[c][t] <= hist[c][t-1];
        end
      end
    end
  end

  // Valid and sticky bad-channel error alongside the history update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1          <= 1'b0;
      err_bad_channel <= 1'b0;
    end else begin
      vld_p1 <= vld_p0;
      if (vld_p0 && ch_p0 == 2'd3)
        err_bad_channel <= 1'b1;
    end
  end

  // Channel tag follows its valid into the flag stage.
  always_ff @(posedge clk) begin
    ch_p1 <= ch_p0;
  end

  // Next-state flag values for the channel being evaluated.
  always_comb begin
    for (int c = 0; c < 3; c++) begin
      filt[c]   = filt_of(sum[c]);
      upd[c]    = vld_p1 && (ch_p1 == 2'(c));
      obst_n[c] = hyst_next(obst[c], filt[c]);
    end
    for (int s = 0; s < 2; s++)
      clr_cnt_n[s] = clear_cnt_next(clr_cnt[s], filt[s+1]);
  end

`ifdef STALE_WATCHDOG_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0] TIMEOUT_V = TO_W'(TIMEOUT);

  logic [TO_W-1:0] to_cnt [3];
  logic [2:0]      stale_q;
  logic [2:0]      stale_set;

  // Per-channel idle counter, restarted by each accepted sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < 3; c++)
        to_cnt[c] <= '0;
    end else begin
      for (int c = 0; c < 3; c++) begin
        if (xfer && sample_channel == 2'(c))
          to_cnt[c] <= '0;
        else if (to_cnt[c] != TIMEOUT_V)
          to_cnt[c] <= to_cnt[c] + 1'b1;
      end
    end
  end

  always_comb begin
    for (int c = 0; c < 3; c++)
      stale_set[c] = (to_cnt[c] == TIMEOUT_V);
  end

  // Stale flag: raised at timeout, lowered by the next flag update of that channel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stale_q <= 3'b000;
    else begin
      for (int c = 0; c < 3; c++) begin
        if (upd[c])
          stale_q[c] <= 1'b0;
        else if (stale_set[c])
          stale_q[c] <= 1'b1;
      end
    end
  end

  assign force_fs  = stale_set | stale_q;
  assign stale_vec = stale_q;
`else
  assign force_fs  = 3'b000;
  assign stale_vec = 3'b000;
`endif

  // ---- p2: registered flags ----
  // Evaluate the sampled channel; stale channels are held in the fail-safe state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      obst            <= 3'b000;
      slow            <= 1'b0;
      lane            <= 2'b00;
      front_dist_filt <= '1;
      for (int s = 0; s < 2; s++)
        clr_cnt[s] <= '0;
    end else begin
      if (upd[0]) begin
        obst[0]         <= obst_n[0];
        slow            <= in_slow_band(filt[0]);
        front_dist_filt <= filt[0];
      end else if (force_fs[0]) begin
        obst[0] <= 1'b1;
        slow    <= 1'b0;
      end
      for (int s = 0; s < 2; s++) begin
        if (upd[s+1]) begin
          obst[s+1]  <= obst_n[s+1];
          clr_cnt[s] <= clr_cnt_n[s];
          lane[s]    <= (clr_cnt_n[s] == HOLD_V) && !obst_n[s+1];
        end else if (force_fs[s+1]) begin
          obst[s+1]  <= 1'b1;
          clr_cnt[s] <= '0;
          lane[s]    <= 1'b0;
        end
      end
    end
  end

  assign front_obstacle_detected = obst[0];
  assign left_obstacle_detected  = obst[1];
  assign right_obstacle_detected = obst[2];
  assign front_obstacle_slow     = slow;
  assign lane_clear_left         = lane[0];
  assign lane_clear_right        = lane[1];
  assign sensor_stale            = stale_vec;

endmodule

// File: tb/tb_obstacle_sensor_frontend.sv
// Directed testbench for obstacle_sensor_frontend.
// Build with STALE_WATCHDOG_EN defined to exercise the watchdog expectations.
module tb_obstacle_sensor_frontend;

  logic       clk;
  logic       rst;
  logic       sample_valid;
  logic       sample_ready;
  logic [1:0] sample_channel;
  logic [7:0] sample_distance;
  logic       front_obstacle_detected;
  logic       left_obstacle_detected;
  logic       right_obstacle_detected;
  logic       front_obstacle_slow;
  logic       lane_clear_left;
  logic       lane_clear_right;
  logic [7:0] front_dist_filt;
  logic [2:0] sensor_stale;
  logic       err_bad_channel;

  int checks = 0;
  int errors = 0;

  obstacle_sensor_frontend dut (
    .clk                     (clk),
    .rst                     (rst),
    .sample_valid            (sample_valid),
    .sample_ready            (sample_ready),
    .sample_channel          (sample_channel),
    .sample_distance         (sample_distance),
    .front_obstacle_detected (front_obstacle_detected),
    .left_obstacle_detected  (left_obstacle_detected),
    .right_obstacle_detected (right_obstacle_detected),
    .front_obstacle_slow     (front_obstacle_slow),
    .lane_clear_left         (lane_clear_left),
    .lane_clear_right        (lane_clear_right),
    .front_dist_filt         (front_dist_filt),
    .sensor_stale            (sensor_stale),
    .err_bad_channel         (err_bad_channel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Transfer at edge N; returns at the falling edge after N+1.
  task automatic send(input logic [1:0] ch, input logic [7:0] d);
    sample_valid    = 1'b1;
    sample_channel  = ch;
    sample_distance = d;
    @(posedge clk);
    @(negedge clk);
    sample_valid = 1'b0;
    tick();
  endtask

  int exp_a [4];
  int exp_b [4];
  int exp_r [8];

  initial begin
    rst             = 1'b1;
    sample_valid    = 1'b0;
    sample_channel  = 2'd0;
    sample_distance = 8'd0;
    do_reset();

    // Reset state
    chk("rst_ready", sample_ready, 1);
    chk("rst_front_filt", front_dist_filt, 255);
    chk("rst_flags", {front_obstacle_detected, left_obstacle_detected, right_obstacle_detected,
                      front_obstacle_slow, lane_clear_left, lane_clear_right}, 0);
    chk("rst_err", err_bad_channel, 0);
    chk("rst_stale", sensor_stale, 0);

    // Front approaching at 10
    exp_a = '{193, 132, 71, 10};
    for (int i = 0; i < 3; i++) begin
      send(2'd0, 8'd10);
      tick();
      chk($sformatf("f10_filt%0d", i), front_dist_filt, exp_a[i]);
      chk($sformatf("f10_det%0d", i), front_obstacle_detected, 0);
    end
    send(2'd0, 8'd10);
    chk("f10_det_n1", front_obstacle_detected, 0);
    chk("f10_filt_n1", front_dist_filt, 71);
    tick();
    chk("f10_filt3", front_dist_filt, 10);
    chk("f10_det_n2", front_obstacle_detected, 1);
    chk("f10_slow", front_obstacle_slow, 0);

    // Inside hysteresis band: detection holds
    exp_a = '{13, 16, 19, 22};
    exp_b = '{0, 0, 0, 1};
    for (int i = 0; i < 4; i++) begin
      send(2'd0, 8'd22);
      tick();
      chk($sformatf("f22_filt%0d", i), front_dist_filt, exp_a[i]);
      chk($sformatf("f22_det%0d", i), front_obstacle_detected, 1);
      chk($sformatf("f22_slow%0d", i), front_obstacle_slow, exp_b[i]);
    end

    // Release at NEAR_TH+HYST
    exp_a = '{22, 23, 23, 24};
    exp_b = '{1, 1, 1, 0};
    for (int i = 0; i < 4; i++) begin
      send(2'd0, 8'd24);
      tick();
      chk($sformatf("f24_filt%0d", i), front_dist_filt, exp_a[i]);
      chk($sformatf("f24_det%0d", i), front_obstacle_detected, exp_b[i]);
    end

    // Slow band
    do_reset();
    exp_a = '{198, 142, 86, 30};
    for (int i = 0; i < 4; i++) begin
      send(2'd0, 8'd30);
      tick();
      chk($sformatf("f30_filt%0d", i), front_dist_filt, exp_a[i]);
    end
    chk("f30_slow", front_obstacle_slow, 1);
    chk("f30_det", front_obstacle_detected, 0);

    // Left lane clear qualification and drop
    do_reset();
    exp_b = '{0, 0, 1, 0};
    for (int i = 0; i < 3; i++) begin
      send(2'd1, 8'd100);
      tick();
      chk($sformatf("l100_lane%0d", i), lane_clear_left, exp_b[i]);
    end
    send(2'd1, 8'd0);
    chk("l0_lane_n1", lane_clear_left, 1);
    tick();
    chk("l0_lane_n2", lane_clear_left, 0);
    chk("l0_det", left_obstacle_detected, 0);
    chk("l_front_untouched", front_dist_filt, 255);
    chk("l_right_lane", lane_clear_right, 0);

    // Right lane clear and drop
    for (int i = 0; i < 3; i++) begin
      send(2'd2, 8'd100);
      tick();
    end
    chk("r100_lane", lane_clear_right, 1);
    chk("r100_left_lane", lane_clear_left, 0);
    send(2'd2, 8'd5);
    tick();
    chk("r5_lane", lane_clear_right, 0);

    // Reset during a pending update
    do_reset();
    sample_valid    = 1'b1;
    sample_channel  = 2'd0;
    sample_distance = 8'd0;
    @(posedge clk);
    #1;
    chk("mid_ready_busy", sample_ready, 0);
    rst = 1'b1;
    sample_valid = 1'b0;
    #1;
    chk("mid_ready_rst", sample_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    tick();
    tick();
    chk("mid_filt", front_dist_filt, 255);
    chk("mid_det", front_obstacle_detected, 0);

    // Continuous valid: one transfer every second cycle
    do_reset();
    exp_r = '{1, 0, 1, 0, 1, 0, 1, 0};
    exp_a = '{10, 20, 30, 40};
    sample_valid   = 1'b1;
    sample_channel = 2'd0;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("stream_ready%0d", k), sample_ready, exp_r[k]);
      sample_distance = (k % 2 == 0) ? 8'(exp_a[k/2]) : 8'd200;
      @(posedge clk);
      @(negedge clk);
    end
    sample_valid = 1'b0;
    tick();
    chk("stream_filt", front_dist_filt, 25);
    chk("stream_slow", front_obstacle_slow, 1);

    // Illegal channel
    send(2'd3, 8'd0);
    tick();
    chk("bad_err", err_bad_channel, 1);
    chk("bad_filt", front_dist_filt, 25);
    chk("bad_flags", {front_obstacle_detected, left_obstacle_detected, right_obstacle_detected,
                      front_obstacle_slow, lane_clear_left, lane_clear_right}, 6'b000100);
    send(2'd0, 8'd25);
    tick();
    chk("bad_err_sticky", err_bad_channel, 1);

    // Watchdog: right channel starved
    do_reset();
    for (int i = 0; i < 170; i++) begin
      send(2'd0, 8'd255);
      tick();
      send(2'd1, 8'd255);
      tick();
    end
`ifdef STALE_WATCHDOG_EN
    chk("wd_stale", sensor_stale, 3'b100);
    chk("wd_right_det", right_obstacle_detected, 1);
    chk("wd_right_lane", lane_clear_right, 0);
    chk("wd_left_det", left_obstacle_detected, 0);
    send(2'd2, 8'd255);
    chk("wd_stale_n1", sensor_stale, 3'b100);
    tick();
    chk("wd_stale_n2", sensor_stale, 3'b000);
    chk("wd_right_det_n2", right_obstacle_detected, 0);
`else
    chk("nowd_stale", sensor_stale, 3'b000);
    chk("nowd_right_det", right_obstacle_detected, 0);
    send(2'd2, 8'd255);
    tick();
    chk("nowd_stale_after", sensor_stale, 3'b000);
`endif
    chk("wd_left_lane", lane_clear_left, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
